decimal_entry_to_binary: RTL and testbench
==========================================

Name: decimal_entry_to_binary

Overview:
- Sequential front end that builds a signed 10-bit two's-complement value from decimal digit keystrokes (most significant digit first) plus a sign toggle.
- Inverse of the binary-to-seven-segment display path: converts human decimal entry back into the binary format the display path consumes.
- Feeds the processor/IO register on enter, with a valid/ack handshake.
- Exposes a live value that can be routed straight into the display converter for echo.

Parameters:
- WIDTH, 10, width of the signed result.
- MAX_DIGITS, 3, maximum decimal digits accepted per entry.
- POS_LIMIT, 511, largest accepted positive magnitude.
- NEG_LIMIT, 512, largest accepted negative magnitude.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- digit_strobe  in  1  one-cycle pulse; digit_in is valid.
- digit_in  in  4  BCD digit; legal values 0-9.
- sign_strobe  in  1  one-cycle pulse; toggles the sign.
- enter_strobe  in  1  one-cycle pulse; commits the current entry.
- clear_strobe  in  1  one-cycle pulse; aborts and returns to IDLE.
- result_ack  in  1  consumer accepts the result.
- result_output_10b  out  WIDTH  committed signed result; held while result_valid=1.
- result_valid  out  1  result available.
- live_value_10b  out  WIDTH  signed value currently entered, for display echo.
- digit_count  out  2  number of digits accepted so far (0..MAX_DIGITS).
- overflow  out  1  entry exceeded its limit; sticky until clear or reset.
- bad_digit  out  1  one-cycle pulse when digit_in > 9 is strobed.

Behaviour:
- Reset values: state=IDLE; acc=0; negative=0; digit_count=0; result_output_10b=0; result_valid=0; overflow=0; bad_digit=0.
- Reset asserted mid-entry discards the entry immediately, asynchronously.
- State IDLE (no digits entered):
  - digit -> ENTRY.
  - sign toggles negative.
  - enter commits 0.
- State ENTRY:
  - Each legal digit computes acc_next = acc*10 + digit, evaluated at 12 bits (shift-add: acc<<3 + acc<<1 + d).
  - If acc_next exceeds the limit (POS_LIMIT when negative=0, NEG_LIMIT when negative=1): go to ERROR, set overflow=1, leave acc unchanged.
  - Otherwise acc <= acc_next and digit_count increments.
  - Digits arriving once digit_count==MAX_DIGITS are silently ignored.
- Illegal digit (>9) in any state: ignored, bad_digit pulses for 1 cycle.
- Sign toggle check: a sign toggle that makes acc exceed the new limit (e.g. 512 toggled to positive) -> ERROR, overflow=1.
- Enter (IDLE or ENTRY):
  - On the next edge: result_output_10b = negative ? -acc : acc, result_valid=1, state=DONE. Latency is 1 cycle.
  - Negative zero commits 0.
- State DONE:
  - Digit, sign and enter are ignored.
  - result_ack=1 at an edge: result_valid<=0, acc/negative/digit_count cleared, state=IDLE. result_output_10b keeps its last value.
- State ERROR: only clear (or reset) exits. Enter is ignored; result_valid stays 0.
- clear_strobe in any state:
  - Next edge: IDLE, acc=0, negative=0, digit_count=0, overflow=0, result_valid=0.
- Same-cycle priority: clear > result_ack > enter > sign > digit. Lower-priority strobes in that cycle are dropped, not queued.
- live_value_10b is combinational from state:
  - signed acc in IDLE/ENTRY.
  - result_output_10b in DONE.
  - 0 in ERROR.
- Arithmetic: acc is an unsigned 10-bit magnitude. Negation is the 10-bit two's complement, so -512 = 10'h200.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, ENTRY=2'd1, DONE=2'd2, ERROR=2'd3.
  - Constants: POS_LIMIT, NEG_LIMIT, MAX_DIGITS, DIGIT_MAX=9.
- One combinational sub-module: decimal_shift_add.
  - Inputs: 10-bit acc, 4-bit digit.
  - Outputs: 12-bit acc*10+digit.
- FSM, limit compare, sign and handshake logic stay in the top module.

Test Plan:
- Strobe digits 1,2,3 then enter -> next cycle result_valid=1, result_output_10b=10'd123, digit_count=3; result_ack -> result_valid=0, state IDLE, live_value_10b=0.
- Sign, then digits 5,1,2, then enter -> result_output_10b=10'h200 (-512), overflow=0.
- Digits 5,1,2 positive -> third digit sets overflow=1 and live_value_10b=0; enter is ignored (result_valid stays 0); clear -> overflow=0, state IDLE.
- Digits 0,0,7,9 then enter -> 4th digit ignored, result=7; digit_in=4'hC strobed -> bad_digit pulses for 1 cycle and acc is unchanged.
- Digits 4,2 with enter and clear strobed in the same cycle -> clear wins: result_valid=0, acc=0.
- Digit 8 then reset pulse mid-entry -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/decimal_entry_to_binary_pkg.sv
// Shared constants and state encoding for the decimal keypad entry path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package decimal_entry_to_binary_pkg;

    localparam int WIDTH      = 10;
    localparam int SUM_WIDTH  = WIDTH + 2;
    localparam int MAX_DIGITS = 3;
    localparam int POS_LIMIT  = 511;
    localparam int NEG_LIMIT  = 512;
    localparam int DIGIT_MAX  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } entry_state_t;

endpackage

// File: rtl/decimal_shift_add.sv
// Computes acc*10 + digit as (acc<<3) + (acc<<1) + digit, two bits wider than acc.
// Latency: combinational.
// Backpressure: none.
import decimal_entry_to_binary_pkg::*;

module decimal_shift_add (
    input  logic [WIDTH-1:0]     acc,
    input  logic [3:0]           digit,
    output logic [SUM_WIDTH-1:0] acc_x10
);

    logic [SUM_WIDTH-1:0] acc_ext;
    logic [SUM_WIDTH-1:0] digit_ext;

    assign acc_ext   = {2'b00, acc};
    assign digit_ext = {{(SUM_WIDTH-4){1'b0}}, digit};

    // Digits are only folded in while acc < 100, so the 12-bit sum never wraps.
    assign acc_x10 = (acc_ext << 3) + (acc_ext << 1) + digit_ext;

endmodule

// File: rtl/decimal_entry_to_binary.sv
// Builds a signed two's-complement value from decimal keystrokes plus sign toggle.
// Latency: result_valid/result_output_10b appear one edge after enter_strobe.
// Backpressure: result held in DONE until result_ack; further entry is ignored meanwhile.
import decimal_entry_to_binary_pkg::*;

module decimal_entry_to_binary (
    input  logic             clock,
    input  logic             reset,
    input  logic             digit_strobe,
    input  logic [3:0]       digit_in,
    input  logic             sign_strobe,
    input  logic             enter_strobe,
    input  logic             clear_strobe,
    input  logic             result_ack,
    output logic [WIDTH-1:0] result_output_10b,
    output logic             result_valid,
    output logic [WIDTH-1:0] live_value_10b,
    output logic [1:0]       digit_count,
    output logic             overflow,
    output logic             bad_digit
);

    localparam logic [SUM_WIDTH-1:0] POS_LIM = SUM_WIDTH'(POS_LIMIT);
    localparam logic [SUM_WIDTH-1:0] NEG_LIM = SUM_WIDTH'(NEG_LIMIT);
    localparam logic [1:0]           CNT_MAX = 2'(MAX_DIGITS);
    localparam logic [3:0]           DIG_MAX = 4'(DIGIT_MAX);

    entry_state_t         state, state_nxt;
    logic [WIDTH-1:0]     acc, acc_nxt;
    logic                 negative, negative_nxt;
    logic [1:0]           count_nxt;
    logic [WIDTH-1:0]     result_nxt;
    logic                 valid_nxt;
    logic                 overflow_nxt;
    logic                 bad_nxt;
    logic [SUM_WIDTH-1:0] acc_x10;
    logic [WIDTH-1:0]     signed_acc;
    logic                 entering;

    decimal_shift_add u_shift_add (
        .acc     (acc),
        .digit   (digit_in),
        .acc_x10 (acc_x10)
    );

    // Two's-complement view of the magnitude; -0 collapses to 0 naturally.
    assign signed_acc = negative ? ({WIDTH{1'b0}} - acc) : acc;
    assign entering   = (state == IDLE) || (state == ENTRY);

    // Next-state logic: one winning strobe per cycle, clear > ack > enter > sign > digit.
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        negative_nxt = negative;
        count_nxt    = digit_count;
        result_nxt   = result_output_10b;
        valid_nxt    = result_valid;
        overflow_nxt = overflow;
        bad_nxt      = 1'b0;

        if (clear_strobe) begin
            state_nxt    = IDLE;
            acc_nxt      = '0;
            negative_nxt = 1'b0;
            count_nxt    = 2'd0;
            overflow_nxt = 1'b0;
            valid_nxt    = 1'b0;
        end else if ((state == DONE) && result_ack) begin
            state_nxt    = IDLE;
            acc_nxt      = '0;
            negative_nxt = 1'b0;
            count_nxt    = 2'd0;
            valid_nxt    = 1'b0;
        end else if (enter_strobe) begin
            if (entering) begin
                result_nxt = signed_acc;
                valid_nxt  = 1'b1;
                state_nxt  = DONE;
            end
        end else if (sign_strobe) begin
            if (entering) begin
                // The limit that applies after the toggle is the opposite one.
                if ({2'b00, acc} > (negative ? POS_LIM : NEG_LIM)) begin
                    state_nxt    = ERROR;
                    overflow_nxt = 1'b1;
                end else begin
                    negative_nxt = ~negative;
                end
            end
        end else if (digit_strobe) begin
            if (digit_in > DIG_MAX) begin
                bad_nxt = 1'b1;
            end else if (entering && (digit_count < CNT_MAX)) begin
                if (acc_x10 > (negative ? NEG_LIM : POS_LIM)) begin
                    state_nxt    = ERROR;
                    overflow_nxt = 1'b1;
                end else begin
                    acc_nxt   = acc_x10[WIDTH-1:0];
                    count_nxt = digit_count + 2'd1;
                    state_nxt = ENTRY;
                end
            end
        end
    end

    // State and output registers; reset discards any entry immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            acc               <= '0;
            negative          <= 1'b0;
            digit_count       <= 2'd0;
            result_output_10b <= '0;
            result_valid      <= 1'b0;
            overflow          <= 1'b0;
            bad_digit         <= 1'b0;
        end else begin
            state             <= state_nxt;
            acc               <= acc_nxt;
            negative          <= negative_nxt;
            digit_count       <= count_nxt;
            result_output_10b <= result_nxt;
            result_valid      <= valid_nxt;
            overflow          <= overflow_nxt;
            bad_digit         <= bad_nxt;
        end
    end

    // Echo value for the display path, chosen by state.
    always_comb begin
        live_value_10b = '0;
        case (state)
            IDLE, ENTRY: live_value_10b = signed_acc;
            DONE:        live_value_10b = result_output_10b;
            default:     live_value_10b = '0;
        endcase
    end

endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// Self-checking bench: directed scenarios plus random keystrokes vs. an arithmetic model.
// Latency: checks one edge after each stimulus cycle.
// Backpressure: exercises result hold until result_ack.
module tb_decimal_entry_to_binary;

    logic       clock = 1'b0;
    logic       reset;
    logic       digit_strobe, sign_strobe, enter_strobe, clear_strobe, result_ack;
    logic [3:0] digit_in;
    logic [9:0] result_output_10b;
    logic       result_valid;
    logic [9:0] live_value_10b;
    logic [1:0] digit_count;
    logic       overflow;
    logic       bad_digit;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer magnitude, sign and flags.
    int m_mag, m_cnt, m_res;
    bit m_neg, m_done, m_err, m_valid, m_ovf, m_bad;

    decimal_entry_to_binary dut (
        .clock             (clock),
        .reset             (reset),
        .digit_strobe      (digit_strobe),
        .digit_in          (digit_in),
        .sign_strobe       (sign_strobe),
        .enter_strobe      (enter_strobe),
        .clear_strobe      (clear_strobe),
        .result_ack        (result_ack),
        .result_output_10b (result_output_10b),
        .result_valid      (result_valid),
        .live_value_10b    (live_value_10b),
        .digit_count       (digit_count),
        .overflow          (overflow),
        .bad_digit         (bad_digit)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap10(input int v);
        return v & 1023;
    endfunction

    task automatic model_reset();
        m_mag = 0; m_cnt = 0; m_res = 0;
        m_neg = 0; m_done = 0; m_err = 0; m_valid = 0; m_ovf = 0; m_bad = 0;
    endtask

    task automatic model_step(input bit dg, input int d, input bit sg, input bit en,
                              input bit ak, input bit cl);
        int nv;
        m_bad = 0;
        if (cl) begin
            m_mag = 0; m_cnt = 0; m_neg = 0; m_done = 0; m_err = 0; m_valid = 0; m_ovf = 0;
        end else if (m_done && ak) begin
            m_mag = 0; m_cnt = 0; m_neg = 0; m_done = 0; m_valid = 0;
        end else if (en) begin
            if (!m_done && !m_err) begin
                m_res = m_neg ? wrap10(-m_mag) : m_mag;
                m_valid = 1; m_done = 1;
            end
        end else if (sg) begin
            if (!m_done && !m_err) begin
                if (m_mag > (m_neg ? 511 : 512)) begin
                    m_err = 1; m_ovf = 1;
                end else begin
                    m_neg = !m_neg;
                end
            end
        end else if (dg) begin
            if (d > 9) begin
                m_bad = 1;
            end else if (!m_done && !m_err && m_cnt < 3) begin
                nv = m_mag * 10 + d;
                if (nv > (m_neg ? 512 : 511)) begin
                    m_err = 1; m_ovf = 1;
                end else begin
                    m_mag = nv; m_cnt++;
                end
            end
        end
    endtask

    function automatic int model_live();
        if (m_err)  return 0;
        if (m_done) return m_res;
        return m_neg ? wrap10(-m_mag) : m_mag;
    endfunction

    task automatic compare_all();
        check_val("valid",    result_valid,      m_valid);
        check_val("result",   result_output_10b, m_res);
        check_val("live",     live_value_10b,    model_live());
        check_val("count",    digit_count,       m_cnt);
        check_val("overflow", overflow,          m_ovf);
        check_val("bad",      bad_digit,         m_bad);
    endtask

    task automatic cycle(input bit dg, input int d, input bit sg, input bit en,
                         input bit ak, input bit cl);
        digit_strobe = dg; digit_in = 4'(d); sign_strobe = sg;
        enter_strobe = en; result_ack = ak; clear_strobe = cl;
        @(posedge clock);
        model_step(dg, d, sg, en, ak, cl);
        #1;
        compare_all();
        digit_strobe = 0; sign_strobe = 0; enter_strobe = 0; result_ack = 0; clear_strobe = 0;
    endtask

    task automatic dig(input int d);  cycle(1, d, 0, 0, 0, 0); endtask
    task automatic sgn();             cycle(0, 0, 1, 0, 0, 0); endtask
    task automatic ent();             cycle(0, 0, 0, 1, 0, 0); endtask
    task automatic ack();             cycle(0, 0, 0, 0, 1, 0); endtask
    task automatic clr();             cycle(0, 0, 0, 0, 0, 1); endtask
    task automatic nop();             cycle(0, 0, 0, 0, 0, 0); endtask

    initial begin
        reset = 1; digit_strobe = 0; digit_in = 0; sign_strobe = 0;
        enter_strobe = 0; clear_strobe = 0; result_ack = 0;
        model_reset();
        #12;
        check_val("rst_valid",  result_valid, 0);
        check_val("rst_result", result_output_10b, 0);
        check_val("rst_live",   live_value_10b, 0);
        check_val("rst_count",  digit_count, 0);
        check_val("rst_ovf",    overflow, 0);
        check_val("rst_bad",    bad_digit, 0);
        @(negedge clock);
        reset = 0;

        // 1,2,3 enter -> 123
        dig(1); dig(2); dig(3); ent();
        check_val("t1_result", result_output_10b, 123);
        check_val("t1_valid",  result_valid, 1);
        check_val("t1_count",  digit_count, 3);
        ack();
        check_val("t1_ack_valid", result_valid, 0);
        check_val("t1_ack_live",  live_value_10b, 0);

        // -512 commits as 10'h200
        sgn(); dig(5); dig(1); dig(2); ent();
        check_val("t2_result", result_output_10b, 10'h200);
        check_val("t2_ovf",    overflow, 0);
        ack();

        // +512 overflows; enter ignored; clear recovers
        dig(5); dig(1); dig(2);
        check_val("t3_ovf",  overflow, 1);
        check_val("t3_live", live_value_10b, 0);
        ent();
        check_val("t3_valid", result_valid, 0);
        clr();
        check_val("t3_clr_ovf", overflow, 0);

        // fourth digit ignored; illegal digit pulses bad_digit
        dig(0); dig(0); dig(7); dig(9); ent();
        check_val("t4_result", result_output_10b, 7);
        ack();
        dig(3); dig(12);
        check_val("t4_bad",  bad_digit, 1);
        check_val("t4_live", live_value_10b, 3);
        nop();
        check_val("t4_bad_off", bad_digit, 0);
        clr();

        // 512 positive-after-toggle overflow through the sign path
        sgn(); dig(5); dig(1); dig(2); sgn();
        check_val("t5_sign_ovf", overflow, 1);
        clr();

        // clear beats enter in the same cycle
        dig(4); dig(2); cycle(0, 0, 0, 1, 0, 1);
        check_val("t6_valid", result_valid, 0);
        check_val("t6_live",  live_value_10b, 0);

        // asynchronous reset mid-entry
        dig(8);
        #2 reset = 1;
        #1;
        check_val("t7_live",  live_value_10b, 0);
        check_val("t7_count", digit_count, 0);
        check_val("t7_valid", result_valid, 0);
        #1 reset = 0;
        model_reset();

        // randomized keystrokes
        for (int i = 0; i < 2000; i++) begin
            int r, d;
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            if (r < 45)      dig(d);
            else if (r < 53) sgn();
            else if (r < 63) ent();
            else if (r < 75) ack();
            else if (r < 79) clr();
            else if (r < 86) cycle($urandom_range(0, 1), d, $urandom_range(0, 1),
                                   $urandom_range(0, 1), $urandom_range(0, 1),
                                   ($urandom_range(0, 3) == 0));
            else             nop();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
